// File: rtl/lb_arbiter_if.sv
// Signal bundle for lb_arbiter: two master request ports, the local-bus
// write/read request ports and the busy flag.
interface lb_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int STRB_W = DATA_W / 8
);
    // Master 0
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic [STRB_W-1:0] m0_wstrb;
    logic              m0_ack;
    logic [DATA_W-1:0] m0_rdata;
    logic              m0_err;

    // Master 1
    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic [STRB_W-1:0] m1_wstrb;
    logic              m1_ack;
    logic [DATA_W-1:0] m1_rdata;
    logic              m1_err;

    // Local-bus write and read channels
    logic [ADDR_W-1:0] lb_waddr;
    logic [DATA_W-1:0] lb_wdata;
    logic              lb_wen;
    logic [STRB_W-1:0] lb_wstrb;
    logic              lb_wready;
    logic [ADDR_W-1:0] lb_raddr;
    logic              lb_ren;
    logic [DATA_W-1:0] lb_rdata;
    logic              lb_rvalid;

    logic              busy;

    // Arbiter side: serves the masters, drives the local bus.
    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_wstrb,
        output m0_ack, m0_rdata, m0_err,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb,
        output m1_ack, m1_rdata, m1_err,
        output lb_waddr, lb_wdata, lb_wen, lb_wstrb,
        input  lb_wready,
        output lb_raddr, lb_ren,
        input  lb_rdata, lb_rvalid,
        output busy
    );

    // Environment side: the two masters plus the local-bus slave.
    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_wstrb,
        input  m0_ack, m0_rdata, m0_err,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb,
        input  m1_ack, m1_rdata, m1_err,
        input  lb_waddr, lb_wdata, lb_wen, lb_wstrb,
        output lb_wready,
        input  lb_raddr, lb_ren,
        output lb_rdata, lb_rvalid,
        input  busy
    );
endinterface

// File: rtl/lb_arbiter.sv
// Two-master round-robin arbiter onto a single local bus with separate write
// and read channels, a per-transaction wait timeout and registered outputs.
module lb_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int STRB_W  = DATA_W / 8,
    parameter int TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         rst,
    lb_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int CNT_W = $clog2(TIMEOUT + 2);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic [DATA_W-1:0] RD_TIMEOUT_DATA = DATA_W'(16'hDEAD);

    state_t            state;
    logic [CNT_W-1:0]  wait_cnt;
    logic              last_grant;  // index of the master granted most recently
    logic              grant;       // index of the master owning the bus now

    logic              sel;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [STRB_W-1:0] sel_wstrb;
    logic              handshake;
    logic              expired;
    logic [DATA_W-1:0] rd_result;

    // Round-robin pick and completion detection.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        sel = 1'b0;
        if (bus.m0_req && bus.m1_req) begin
            sel = ~last_grant;
        end else if (bus.m1_req) begin
            sel = 1'b1;
        end

        sel_we    = sel ? bus.m1_we    : bus.m0_we;
        sel_addr  = sel ? bus.m1_addr  : bus.m0_addr;
        sel_wdata = sel ? bus.m1_wdata : bus.m0_wdata;
        sel_wstrb = sel ? bus.m1_wstrb : bus.m0_wstrb;

        handshake = ((state == WR) && bus.lb_wen && bus.lb_wready) ||
                    ((state == RD) && bus.lb_ren && bus.lb_rvalid);
        // A handshake in the cycle the counter hits its limit still completes cleanly.
        expired   = ((state == WR) || (state == RD)) && !handshake &&
                    (wait_cnt == TIMEOUT_CNT);
        rd_result = handshake ? bus.lb_rdata : RD_TIMEOUT_DATA;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            last_grant   <= 1'b1;
            grant        <= 1'b0;
            bus.busy     <= 1'b0;
            bus.lb_wen   <= 1'b0;
            bus.lb_ren   <= 1'b0;
            bus.lb_waddr <= '0;
            bus.lb_wdata <= '0;
            bus.lb_wstrb <= '0;
            bus.lb_raddr <= '0;
            bus.m0_ack   <= 1'b0;
            bus.m0_err   <= 1'b0;
            bus.m0_rdata <= '0;
            bus.m1_ack   <= 1'b0;
            bus.m1_err   <= 1'b0;
            bus.m1_rdata <= '0;
        end else begin
            bus.m0_ack <= 1'b0;
            bus.m1_ack <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.m0_req || bus.m1_req) begin
                        grant      <= sel;
                        last_grant <= sel;
                        wait_cnt   <= '0;
                        bus.busy   <= 1'b1;
                        if (sel_we) begin
                            state        <= WR;
                            bus.lb_wen   <= 1'b1;
                            bus.lb_waddr <= sel_addr;
                            bus.lb_wdata <= sel_wdata;
                            bus.lb_wstrb <= sel_wstrb;
                        end else begin
                            state        <= RD;
                            bus.lb_ren   <= 1'b1;
                            bus.lb_raddr <= sel_addr;
                        end
                    end
                end

                WR, RD: begin
                    if (handshake || expired) begin
                        state      <= DONE;
                        bus.lb_wen <= 1'b0;
                        bus.lb_ren <= 1'b0;
                        bus.m0_ack <= ~grant;
                        bus.m1_ack <= grant;
                        bus.m0_err <= ~grant && expired;
                        bus.m1_err <= grant && expired;
                        // Read data is per master and held until that master's next read.
                        if (state == RD) begin
                            if (grant) begin
                                bus.m1_rdata <= rd_result;
                            end else begin
                                bus.m0_rdata <= rd_result;
                            end
                        end
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end

                DONE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end

                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lb_arbiter.sv
// Self-checking bench for lb_arbiter: directed latency/timeout/reset cases,
// round-robin contention and random traffic against a transaction-level model.
module tb_lb_arbiter;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 16;
    localparam int STRB_W  = 2;
    localparam int TIMEOUT = 15;
    localparam int NEVER   = 1000;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    lb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W)) bus ();

    lb_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .STRB_W (STRB_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Local-bus slave: accepts after slv_lat cycles of a held request.
    logic [15:0] slv_mem [256];
    int          slv_lat = 0;
    int          wcnt = 0;
    int          rcnt = 0;

    // Reference model state.
    logic [15:0] ref_mem [256];
    logic [15:0] rd_hold [2];
    int          last_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        check("wen_ren_excl", 32'(bus.lb_wen & bus.lb_ren), 32'd0);
        if (bus.lb_wen === 1'b1) wcnt++; else wcnt = 0;
        if (bus.lb_ren === 1'b1) rcnt++; else rcnt = 0;
        bus.lb_wready = (bus.lb_wen === 1'b1) && (wcnt > slv_lat);
        bus.lb_rvalid = (bus.lb_ren === 1'b1) && (rcnt > slv_lat);
        if (bus.lb_wready) begin
            for (int b = 0; b < STRB_W; b++)
                if (bus.lb_wstrb[b]) slv_mem[bus.lb_waddr][8*b +: 8] = bus.lb_wdata[8*b +: 8];
        end
        bus.lb_rdata = bus.lb_rvalid ? slv_mem[bus.lb_raddr] : 16'($urandom);
    end

    function automatic logic ack_of(input int m);
        return (m == 1) ? bus.m1_ack : bus.m0_ack;
    endfunction

    function automatic logic err_of(input int m);
        return (m == 1) ? bus.m1_err : bus.m0_err;
    endfunction

    function automatic logic [15:0] rdata_of(input int m);
        return (m == 1) ? bus.m1_rdata : bus.m0_rdata;
    endfunction

    // Zero-wait write acks at cycle 2; each slave wait cycle adds one, capped by the timeout.
    function automatic int exp_ack_cycle(input int lat);
        return ((lat > TIMEOUT) ? TIMEOUT : lat) + 2;
    endfunction

    task automatic drive(input int m, input logic req, input logic we, input logic [7:0] a,
                         input logic [15:0] wd, input logic [1:0] ws);
        if (m == 0) begin
            bus.m0_req = req; bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = wd; bus.m0_wstrb = ws;
        end else begin
            bus.m1_req = req; bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = wd; bus.m1_wstrb = ws;
        end
    endtask

    task automatic model_write(input logic [7:0] a, input logic [15:0] wd, input logic [1:0] ws);
        for (int b = 0; b < 2; b++)
            if (ws[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
    endtask

    function automatic int rand_lat();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return NEVER;
        if (r == 1) return TIMEOUT;
        return int'($urandom_range(0, 3));
    endfunction

    // Checks a completion seen this cycle and advances the model.
    task automatic complete(input string tag, input int m, input logic we, input logic [7:0] a,
                            input logic [15:0] wd, input logic [1:0] ws, input int lat,
                            input int ack_cyc);
        logic exp_err;
        exp_err = (lat > TIMEOUT);
        check({tag, "_ack_cycle"}, 32'(ack_cyc), 32'(exp_ack_cycle(lat)));
        check({tag, "_err"}, 32'(err_of(m)), 32'(exp_err));
        check({tag, "_other_ack"}, 32'(ack_of(1 - m)), 32'd0);
        check({tag, "_lb_req_low"}, 32'({bus.lb_wen, bus.lb_ren}), 32'd0);
        if (we) begin
            if (!exp_err) model_write(a, wd, ws);
        end else begin
            rd_hold[m] = exp_err ? 16'hDEAD : ref_mem[a];
        end
        check({tag, "_rdata"}, 32'(rdata_of(m)), 32'(rd_hold[m]));
        last_m = m;
    endtask

    task automatic do_single(input string tag, input int m, input logic we, input logic [7:0] a,
                             input logic [15:0] wd, input logic [1:0] ws, input int lat);
        int wen_n, ren_n, wen_first, ren_first, ack_cyc, eff;
        wen_n = 0; ren_n = 0; wen_first = 0; ren_first = 0; ack_cyc = 0;
        eff = (lat > TIMEOUT) ? TIMEOUT : lat;
        slv_lat = lat;
        drive(m, 1'b1, we, a, wd, ws);
        for (int k = 1; k <= TIMEOUT + 6 && ack_cyc == 0; k++) begin
            @(negedge clk);
            if (k == 1) check({tag, "_busy_c1"}, 32'(bus.busy), 32'd1);
            if (bus.lb_wen) begin
                wen_n++;
                if (wen_first == 0) begin
                    wen_first = k;
                    check({tag, "_waddr"}, 32'(bus.lb_waddr), 32'(a));
                    check({tag, "_wdata"}, 32'(bus.lb_wdata), 32'(wd));
                    check({tag, "_wstrb"}, 32'(bus.lb_wstrb), 32'(ws));
                end
            end
            if (bus.lb_ren) begin
                ren_n++;
                if (ren_first == 0) begin
                    ren_first = k;
                    check({tag, "_raddr"}, 32'(bus.lb_raddr), 32'(a));
                end
            end
            if (ack_of(m)) begin
                ack_cyc = k;
                complete(tag, m, we, a, wd, ws, lat, ack_cyc);
                drive(m, 1'b0, we, a, wd, ws);
            end
        end
        if (ack_cyc == 0) begin
            check({tag, "_ack_seen"}, 32'd0, 32'd1);
            drive(m, 1'b0, we, a, wd, ws);
        end
        check({tag, "_wen_cycles"}, 32'(wen_n), we ? 32'(eff + 1) : 32'd0);
        check({tag, "_ren_cycles"}, 32'(ren_n), we ? 32'd0 : 32'(eff + 1));
        check({tag, "_first_cycle"}, 32'(we ? wen_first : ren_first), 32'd1);
        @(negedge clk);
        check({tag, "_ack_one_cycle"}, 32'(ack_of(m)), 32'd0);
        check({tag, "_busy_idle"}, 32'(bus.busy), 32'd0);
        check({tag, "_rdata_held"}, 32'(rdata_of(m)), 32'(rd_hold[m]));
    endtask

    // Both masters keep requesting; grants must alternate.
    task automatic do_contend(input int n);
        logic        p_we  [2];
        logic [7:0]  p_a   [2];
        logic [15:0] p_wd  [2];
        logic [1:0]  p_ws  [2];
        int          p_lat [2];
        int          exp_m, got, ack_cyc;
        for (int m = 0; m < 2; m++) begin
            p_we[m] = 1'($urandom_range(0, 1)); p_a[m] = 8'($urandom_range(0, 7));
            p_wd[m] = 16'($urandom); p_ws[m] = 2'($urandom_range(0, 3)); p_lat[m] = rand_lat();
            drive(m, 1'b1, p_we[m], p_a[m], p_wd[m], p_ws[m]);
        end
        for (int i = 0; i < n; i++) begin
            exp_m = 1 - last_m;
            slv_lat = p_lat[exp_m];
            got = -1; ack_cyc = 0;
            for (int k = 1; k <= TIMEOUT + 6 && ack_cyc == 0; k++) begin
                @(negedge clk);
                if (bus.m0_ack || bus.m1_ack) begin
                    ack_cyc = k;
                    got = bus.m1_ack ? 1 : 0;
                end
            end
            check("rr_grant", 32'(got), 32'(exp_m));
            complete("rr", exp_m, p_we[exp_m], p_a[exp_m], p_wd[exp_m], p_ws[exp_m],
                     p_lat[exp_m], ack_cyc);
            drive(exp_m, 1'b0, p_we[exp_m], p_a[exp_m], p_wd[exp_m], p_ws[exp_m]);
            @(negedge clk);
            check("rr_busy_idle", 32'(bus.busy), 32'd0);
            if (i + 2 < n) begin
                p_we[exp_m] = 1'($urandom_range(0, 1)); p_a[exp_m] = 8'($urandom_range(0, 7));
                p_wd[exp_m] = 16'($urandom); p_ws[exp_m] = 2'($urandom_range(0, 3));
                p_lat[exp_m] = rand_lat();
                drive(exp_m, 1'b1, p_we[exp_m], p_a[exp_m], p_wd[exp_m], p_ws[exp_m]);
            end
        end
    endtask

    initial begin
        int ack1, ack2;
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 8'h00, 16'h0000, 2'b00);
        drive(1, 1'b0, 1'b0, 8'h00, 16'h0000, 2'b00);
        bus.lb_wready = 1'b0; bus.lb_rvalid = 1'b0; bus.lb_rdata = 16'h0000;
        for (int i = 0; i < 256; i++) begin
            slv_mem[i] = 16'($urandom);
            ref_mem[i] = slv_mem[i];
        end
        rd_hold[0] = 16'h0000; rd_hold[1] = 16'h0000; last_m = 1;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_wen", 32'(bus.lb_wen), 32'd0);
        check("rst_ren", 32'(bus.lb_ren), 32'd0);
        check("rst_waddr", 32'(bus.lb_waddr), 32'd0);
        check("rst_wdata", 32'(bus.lb_wdata), 32'd0);
        check("rst_wstrb", 32'(bus.lb_wstrb), 32'd0);
        check("rst_raddr", 32'(bus.lb_raddr), 32'd0);
        check("rst_acks", 32'({bus.m0_ack, bus.m1_ack}), 32'd0);
        check("rst_errs", 32'({bus.m0_err, bus.m1_err}), 32'd0);
        check("rst_m0_rdata", 32'(bus.m0_rdata), 32'd0);
        check("rst_m1_rdata", 32'(bus.m1_rdata), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Zero-wait write, then 1-wait read of the same word
        do_single("wr0", 0, 1'b1, 8'h00, 16'h0111, 2'b11, 0);
        do_single("rd1", 1, 1'b0, 8'h00, 16'h0000, 2'b00, 1);
        check("rd1_value", 32'(bus.m1_rdata), 32'h0111);

        // Partial strobes and timeout boundaries
        do_single("wr_lo", 0, 1'b1, 8'h03, 16'hBEEF, 2'b01, 2);
        do_single("rd_lo", 0, 1'b0, 8'h03, 16'h0000, 2'b00, 0);
        do_single("rd_edge", 1, 1'b0, 8'h03, 16'h0000, 2'b00, TIMEOUT);
        do_single("wr_edge", 1, 1'b1, 8'h04, 16'h1234, 2'b11, TIMEOUT);
        do_single("wr_tmo", 0, 1'b1, 8'h04, 16'h5678, 2'b11, TIMEOUT + 1);
        do_single("rd_tmo", 1, 1'b0, 8'h04, 16'h0000, 2'b00, NEVER);
        do_single("rd_after", 1, 1'b0, 8'h04, 16'h0000, 2'b00, 0);

        // Request held high through its ack starts a second transaction
        slv_lat = 0;
        ack1 = 0; ack2 = 0;
        drive(1, 1'b1, 1'b1, 8'h06, 16'hA5C3, 2'b11);
        for (int k = 1; k <= 8 && ack2 == 0; k++) begin
            @(negedge clk);
            if (bus.m1_ack) begin
                if (ack1 == 0) ack1 = k;
                else begin
                    ack2 = k;
                    drive(1, 1'b0, 1'b1, 8'h06, 16'hA5C3, 2'b11);
                end
            end
        end
        check("held_ack1", 32'(ack1), 32'd2);
        check("held_ack2", 32'(ack2), 32'd5);
        model_write(8'h06, 16'hA5C3, 2'b11);
        last_m = 1;
        @(negedge clk);
        check("held_no_third", 32'(bus.m1_ack), 32'd0);
        @(negedge clk);
        check("held_idle", 32'({bus.m1_ack, bus.busy}), 32'd0);

        do_contend(6);

        // Reset while in RD aborts with no ack
        slv_lat = NEVER;
        drive(0, 1'b1, 1'b0, 8'h05, 16'h0000, 2'b00);
        repeat (3) @(negedge clk);
        check("rst_mid_ren", 32'(bus.lb_ren), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_ren_low", 32'(bus.lb_ren), 32'd0);
        check("rst_mid_busy", 32'(bus.busy), 32'd0);
        check("rst_mid_no_ack", 32'({bus.m0_ack, bus.m1_ack}), 32'd0);
        check("rst_mid_rdata", 32'(bus.m0_rdata), 32'd0);
        rst = 1'b0;
        drive(0, 1'b0, 1'b0, 8'h05, 16'h0000, 2'b00);
        rd_hold[0] = 16'h0000; rd_hold[1] = 16'h0000; last_m = 1;
        repeat (3) begin
            @(negedge clk);
            check("rst_mid_quiet", 32'({bus.m0_ack, bus.m1_ack, bus.busy}), 32'd0);
        end
        do_single("post_rst", 0, 1'b0, 8'h00, 16'h0000, 2'b00, 1);
        last_m = 1;  // reset of last grant is re-checked after a fresh reset below
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rd_hold[0] = 16'h0000; rd_hold[1] = 16'h0000;
        @(negedge clk);
        do_contend(4);

        // Random single-master traffic
        for (int i = 0; i < 24; i++) begin
            do_single("rand", int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      8'($urandom_range(0, 7)), 16'($urandom), 2'($urandom_range(0, 3)),
                      rand_lat());
        end
        do_contend(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
